// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the memory BIST controller.
package mbist_pkg;

    localparam int unsigned NumElems = 6;

    typedef logic [2:0] elem_t;

    localparam elem_t M0 = 3'd0;
    localparam elem_t M1 = 3'd1;
    localparam elem_t M2 = 3'd2;
    localparam elem_t M3 = 3'd3;
    localparam elem_t M4 = 3'd4;
    localparam elem_t M5 = 3'd5;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic {OpR, OpW} op_e;

    // One bit per element, bit index = element number.
    localparam logic [NumElems-1:0] ElemDown  = 6'b011000;
    localparam logic [NumElems-1:0] ElemTwoOp = 6'b011110;
    localparam logic [NumElems-1:0] ElemHasRd = 6'b111110;
    localparam logic [NumElems-1:0] ElemRdBg1 = 6'b010100;
    localparam logic [NumElems-1:0] ElemWrBg1 = 6'b001010;

    localparam logic [7:0] Bg0Default = 8'h00;
    localparam logic [7:0] Bg1Default = 8'hFF;

    function automatic logic elem_bit(logic [NumElems-1:0] tbl, elem_t e);
        return (e <= M5) ? tbl[e] : 1'b0;
    endfunction

    function automatic op_e first_op(elem_t e);
        return elem_bit(ElemHasRd, e) ? OpR : OpW;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Control, status and RAM-port bundle between the BIST controller and its surroundings.
interface mbist_march_ctrl_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [DATA_W-1:0] fail_exp;
    logic [DATA_W-1:0] fail_act;
    logic [7:0]        fail_count;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_en;
    logic [DATA_W-1:0] ram_data_out;

    modport master (
        input  start, ram_data_out,
        output busy, done, fail, fail_addr, fail_elem, fail_exp, fail_act, fail_count,
        output ram_addr, ram_data_in, ram_write_en
    );

    modport slave (
        output start, ram_data_out,
        input  busy, done, fail, fail_addr, fail_elem, fail_exp, fail_act, fail_count,
        input  ram_addr, ram_data_in, ram_write_en
    );
endinterface

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; flags the final address of the current sweep.
module mbist_addr_gen #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_dir,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_down;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_down <= i_dir;
            r_addr <= i_dir ? AddrMax : '0;
        end else if (i_step) begin
            r_addr <= r_down ? (r_addr - AddrOne) : (r_addr + AddrOne);
        end
    end

    assign o_addr = r_addr;
    assign o_last = r_down ? (r_addr == '0) : (r_addr == AddrMax);
endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sequences RAM ops, checks reads, records the first failure.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned       ADDR_W = 6,
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       DEPTH  = 32,
    parameter logic [DATA_W-1:0] BG0    = DATA_W'(Bg0Default),
    parameter logic [DATA_W-1:0] BG1    = DATA_W'(Bg1Default)
) (
    input logic                clk,
    input logic                rst,
    mbist_march_ctrl_if.master io_bist
);
    state_e            r_state, w_state_nxt;
    elem_t             r_elem, w_elem_nxt, w_elem_inc;
    op_e               r_op, w_op_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nxt;

    logic              w_load, w_dir, w_step, w_last;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rd_exp;
    logic              w_start_ok, w_miscmp;

    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    elem_t             r_fail_elem;
    logic [DATA_W-1:0] r_fail_exp, r_fail_act;
    logic [7:0]        r_fail_count;

    mbist_addr_gen #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_load),
        .i_dir (w_dir),
        .i_step(w_step),
        .o_addr(w_addr),
        .o_last(w_last)
    );

    assign w_elem_inc = r_elem + 3'd1;
    assign w_start_ok = io_bist.start && (r_state != StRun);
    assign w_rd_exp   = elem_bit(ElemRdBg1, r_elem) ? BG1 : BG0;
    assign w_miscmp   = (r_state == StRun) && (r_op == OpR) && (io_bist.ram_data_out != w_rd_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_elem      <= M0;
            r_op        <= OpW;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_elem      <= w_elem_nxt;
            r_op        <= w_op_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_op_nxt    = r_op;
        w_load      = 1'b0;
        w_dir       = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (io_bist.start) begin
                    w_state_nxt = StRun;
                    w_elem_nxt  = M0;
                    w_op_nxt    = first_op(M0);
                    w_load      = 1'b1;
                    w_dir       = elem_bit(ElemDown, M0);
                end
            end
            StRun: begin
                // Read half of a read/write pair: stay on this address for the write.
                if ((r_op == OpR) && elem_bit(ElemTwoOp, r_elem)) begin
                    w_op_nxt = OpW;
                end else if (!w_last) begin
                    w_step   = 1'b1;
                    w_op_nxt = first_op(r_elem);
                end else if (r_elem == M5) begin
                    w_state_nxt = StDone;
                    w_load      = 1'b1;
                end else begin
                    w_elem_nxt = w_elem_inc;
                    w_op_nxt   = first_op(w_elem_inc);
                    w_load     = 1'b1;
                    w_dir      = elem_bit(ElemDown, w_elem_inc);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_ram_we_nxt    = (w_state_nxt == StRun) && (w_op_nxt == OpW);
        w_ram_wdata_nxt = '0;
        if (w_ram_we_nxt) begin
            w_ram_wdata_nxt = elem_bit(ElemWrBg1, w_elem_nxt) ? BG1 : BG0;
        end
        io_bist.busy         = (r_state == StRun);
        io_bist.done         = (r_state == StDone);
        io_bist.ram_addr     = w_addr;
        io_bist.ram_write_en = r_ram_we;
        io_bist.ram_data_in  = r_ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_elem  <= M0;
            r_fail_exp   <= '0;
            r_fail_act   <= '0;
            r_fail_count <= '0;
        end else if (w_miscmp) begin
            if (r_fail_count != 8'hFF) begin
                r_fail_count <= r_fail_count + 8'd1;
            end
            if (!r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= w_addr;
                r_fail_elem <= r_elem;
                r_fail_exp  <= w_rd_exp;
                r_fail_act  <= io_bist.ram_data_out;
            end
        end
    end

    assign io_bist.fail       = r_fail;
    assign io_bist.fail_addr  = r_fail_addr;
    assign io_bist.fail_elem  = r_fail_elem;
    assign io_bist.fail_exp   = r_fail_exp;
    assign io_bist.fail_act   = r_fail_act;
    assign io_bist.fail_count = r_fail_count;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench: behavioural RAM with injectable faults and a March C- op-list model.
module tb_mbist_march_ctrl;
    logic clk;
    logic rst;

    mbist_march_ctrl_if #(.ADDR_W(6), .DATA_W(8)) bist_if ();

    mbist_march_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .io_bist(bist_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; fault_mode 0 = none, 1 = bit0 stuck-at-1 at addr 5, 2 = w1 @8 sets @9 to FF
    logic [7:0] mem [64];
    int         fault_mode = 0;

    assign bist_if.ram_data_out = mem[bist_if.ram_addr] |
        (((fault_mode == 1) && (bist_if.ram_addr == 6'd5)) ? 8'h01 : 8'h00);

    always @(posedge clk) begin
        if (bist_if.ram_write_en) begin
            mem[bist_if.ram_addr] <= bist_if.ram_data_in;
            if ((fault_mode == 2) && (bist_if.ram_addr == 6'd8) && (bist_if.ram_data_in == 8'hFF))
                mem[9] <= 8'hFF;
        end
    end

    function automatic logic [7:0] rd_model(int a);
        return mem[a] | (((fault_mode == 1) && (a == 5)) ? 8'h01 : 8'h00);
    endfunction

    // March C- as written: direction, read pattern (-1 none), write pattern (-1 none)
    int e_down [6] = '{0, 0, 0, 1, 1, 0};
    int e_rd   [6] = '{-1, 0, 1, 0, 1, 0};
    int e_wr   [6] = '{0, 1, 0, 1, 0, -1};

    typedef struct {
        int         addr;
        bit         we;
        logic [7:0] d;
        logic [7:0] x;
        int         elem;
    } op_t;
    op_t ops [$];

    function automatic void build_ops();
        op_t o;
        ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 32; i++) begin
                o.addr = (e_down[e] != 0) ? 31 - i : i;
                o.elem = e;
                if (e_rd[e] >= 0) begin
                    o.we = 1'b0;
                    o.d  = 8'h00;
                    o.x  = (e_rd[e] == 1) ? 8'hFF : 8'h00;
                    ops.push_back(o);
                end
                if (e_wr[e] >= 0) begin
                    o.we = 1'b1;
                    o.d  = (e_wr[e] == 1) ? 8'hFF : 8'h00;
                    o.x  = 8'h00;
                    ops.push_back(o);
                end
            end
        end
    endfunction

    // Expected failure record
    bit         m_fail;
    int         m_cnt;
    int         m_addr;
    int         m_elem;
    logic [7:0] m_exp;
    logic [7:0] m_act;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_status();
        chk("fail", {63'd0, bist_if.fail}, {63'd0, m_fail});
        chk("fail_count", {56'd0, bist_if.fail_count}, 64'(m_cnt));
        chk("fail_info",
            {39'd0, bist_if.fail_addr, bist_if.fail_elem, bist_if.fail_exp, bist_if.fail_act},
            {39'd0, 6'(m_addr), 3'(m_elem), m_exp, m_act});
    endtask

    // Literal op-trace points: index, address, write_en
    int lit_k [11] = '{0, 31, 32, 33, 160, 161, 162, 223, 224, 288, 319};
    int lit_a [11] = '{0, 31, 0, 0, 31, 31, 30, 0, 31, 0, 31};
    int lit_w [11] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};

    task automatic check_op(input int k, input bit trace);
        logic [7:0] act;
        chk("busy", {63'd0, bist_if.busy}, 64'd1);
        chk("done", {63'd0, bist_if.done}, 64'd0);
        chk("ram_addr", {58'd0, bist_if.ram_addr}, 64'(ops[k].addr));
        chk("ram_write_en", {63'd0, bist_if.ram_write_en}, {63'd0, ops[k].we});
        chk("ram_data_in", {56'd0, bist_if.ram_data_in}, {56'd0, ops[k].d});
        chk_status();
        if (trace) begin
            for (int j = 0; j < 11; j++) begin
                if (lit_k[j] == k)
                    chk("trace_lit", {57'd0, bist_if.ram_addr, bist_if.ram_write_en},
                        64'((lit_a[j] << 1) | lit_w[j]));
            end
        end
        if (!ops[k].we) begin
            act = rd_model(ops[k].addr);
            if (act != ops[k].x) begin
                if (m_cnt < 255) m_cnt++;
                if (!m_fail) begin
                    m_fail = 1'b1;
                    m_addr = ops[k].addr;
                    m_elem = ops[k].elem;
                    m_exp  = ops[k].x;
                    m_act  = act;
                end
            end
        end
    endtask

    task automatic check_all_zero();
        chk("rst_busy", {63'd0, bist_if.busy}, 64'd0);
        chk("rst_done", {63'd0, bist_if.done}, 64'd0);
        chk("rst_fail", {63'd0, bist_if.fail}, 64'd0);
        chk("rst_fail_count", {56'd0, bist_if.fail_count}, 64'd0);
        chk("rst_fail_info",
            {39'd0, bist_if.fail_addr, bist_if.fail_elem, bist_if.fail_exp, bist_if.fail_act},
            64'd0);
        chk("rst_ram_addr", {58'd0, bist_if.ram_addr}, 64'd0);
        chk("rst_ram_write_en", {63'd0, bist_if.ram_write_en}, 64'd0);
        chk("rst_ram_data_in", {56'd0, bist_if.ram_data_in}, 64'd0);
    endtask

    // Cycle 0 is the cycle start is high; op k is visible in cycle k+1, done in cycle 321.
    task automatic run_test(input int fault, input int restart_at, input int rst_at,
                            input bit trace, output int done_cycle, output int wr_n,
                            output int rd_n);
        fault_mode = fault;
        build_ops();
        m_fail = 1'b0; m_cnt = 0; m_addr = 0; m_elem = 0; m_exp = 8'h00; m_act = 8'h00;
        done_cycle = -1; wr_n = 0; rd_n = 0;
        bist_if.start = 1'b1;
        @(posedge clk); #1;
        bist_if.start = 1'b0;
        for (int k = 0; k <= 320; k++) begin
            if (k < 320) begin
                check_op(k, trace);
            end else begin
                chk("end_busy", {63'd0, bist_if.busy}, 64'd0);
                chk("end_done", {63'd0, bist_if.done}, 64'd1);
                chk("end_write_en", {63'd0, bist_if.ram_write_en}, 64'd0);
                chk_status();
                if (bist_if.done) done_cycle = k + 1;
            end
            if (bist_if.busy) begin
                if (bist_if.ram_write_en) wr_n++;
                else rd_n++;
            end
            bist_if.start = (k == restart_at);
            if (k == rst_at) begin
                rst = 1'b1;
                bist_if.start = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                bist_if.start = 1'b0;
                check_all_zero();
                return;
            end
            if (k < 320) begin
                @(posedge clk); #1;
            end
        end
    endtask

    int dc, wn, rn;
    logic [7:0] acc;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'hA5;
        rst = 1'b1;
        bist_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b0;
        @(posedge clk); #1;

        // Fault-free run with address-trace literals
        run_test(0, -1, -1, 1'b1, dc, wn, rn);
        chk("done_cycle_clean", 64'(dc), 64'd321);
        chk("write_cycles", 64'(wn), 64'd160);
        chk("read_cycles", 64'(rn), 64'd160);
        chk("fail_clean", {63'd0, bist_if.fail}, 64'd0);
        chk("count_clean", {56'd0, bist_if.fail_count}, 64'd0);
        acc = 8'h00;
        for (int i = 0; i < 32; i++) acc = acc | mem[i];
        chk("mem_final_zero", {56'd0, acc}, 64'd0);

        // Stuck-at-1 on bit 0 of address 5
        run_test(1, -1, -1, 1'b0, dc, wn, rn);
        chk("sa1_fail", {63'd0, bist_if.fail}, 64'd1);
        chk("sa1_elem", {61'd0, bist_if.fail_elem}, 64'd1);
        chk("sa1_addr", {58'd0, bist_if.fail_addr}, 64'd5);
        chk("sa1_exp", {56'd0, bist_if.fail_exp}, 64'h00);
        chk("sa1_act", {56'd0, bist_if.fail_act}, 64'h01);
        chk("sa1_count", {56'd0, bist_if.fail_count}, 64'd3);

        // Restart from DONE with a stale failure; second start at cycle 50 is ignored
        run_test(0, 50, -1, 1'b0, dc, wn, rn);
        chk("done_cycle_restart", 64'(dc), 64'd321);
        chk("restart_fail", {63'd0, bist_if.fail}, 64'd0);

        // Reset with start at cycle 100 of a failing run, then a clean run from IDLE
        run_test(1, -1, 100, 1'b0, dc, wn, rn);
        @(posedge clk); #1;
        chk("post_rst_idle_busy", {63'd0, bist_if.busy}, 64'd0);
        run_test(0, -1, -1, 1'b0, dc, wn, rn);
        chk("done_cycle_after_rst", 64'(dc), 64'd321);
        chk("after_rst_fail", {63'd0, bist_if.fail}, 64'd0);

        // Coupling fault: writing 1 at address 8 forces address 9 to FF
        run_test(2, -1, -1, 1'b0, dc, wn, rn);
        chk("cf_done_cycle", 64'(dc), 64'd321);
        chk("cf_fail", {63'd0, bist_if.fail}, 64'd1);
        chk("cf_elem", {61'd0, bist_if.fail_elem}, 64'd1);
        chk("cf_addr", {58'd0, bist_if.fail_addr}, 64'd9);
        chk("cf_exp", {56'd0, bist_if.fail_exp}, 64'h00);
        chk("cf_act", {56'd0, bist_if.fail_act}, 64'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
